pulse_burst_scheduler: RTL
==========================

Name: pulse_burst_scheduler

Overview:
- Shares one runtime-programmable pulse engine between NUM_REQ requesters.
- Each requester asks for a burst of pulses, giving its own period, high-duration and pulse count. The scheduler arbitrates round-robin, latches the winner's config and runs the burst.
- It then reports completion (or error) back to the winner.
- Sits between the control agents and the board-level pulse output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 7, width of period/duration fields (period up to 127 clks).
- BURST_W, 8, width of pulse-count field (up to 255 pulses per burst).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset (synchronous, active-high)
- i_req  in  NUM_REQ  level request per requester; held high until o_done for that requester
- i_period  in  NUM_REQ*CNT_W  per-requester period in clks; slice i at [i*CNT_W +: CNT_W]
- i_duration  in  NUM_REQ*CNT_W  per-requester high time in clks
- i_count  in  NUM_REQ*BURST_W  per-requester pulse count
- o_grant  out  NUM_REQ  one-hot current owner; 0 when idle
- o_busy  out  1  high in RUN and DONE
- o_done  out  NUM_REQ  one-cycle completion strobe to the owner
- o_err  out  1  qualifies o_done: 1 = rejected config or aborted burst
- o_pulse  out  1  registered pulse output

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - RR pointer 0 (requester 0 highest priority).
  - Internal counters 0.
- States:
  - IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - If i_req != 0, select the first set bit searching upward from the RR pointer, with wrap.
  - Latch that requester's period, duration and count.
  - Set o_grant one-hot and move the RR pointer to winner+1 (mod NUM_REQ).
  - Config check at the same edge: if period==0, count==0 or duration>period, go to DONE with err_flag=1. Otherwise go to RUN with phase counter 0 and remaining=count.
- RUN:
  - Phase counter counts 0..period-1 and wraps to 0.
  - At each wrap, remaining decrements.
  - When the wrap occurs with remaining==1, go to DONE with err_flag=0.
- Pulse generation:
  - pulse_d = (state==RUN) && (phase < duration); o_pulse is pulse_d registered.
  - Hence o_pulse lags RUN by exactly one cycle.
  - A burst produces exactly count high windows of duration cycles, spaced period cycles apart.
  - duration==period gives o_pulse high continuously for count*period cycles.
  - duration==0 is legal: no high cycles, burst still takes count*period cycles.
- Abort:
  - If the owner's i_req drops while in RUN, go to DONE with err_flag=1 on the next edge.
  - Remaining pulses are discarded. o_pulse goes low one cycle later, per the register lag.
- DONE (exactly one cycle):
  - o_done[owner]=1 and o_err=err_flag.
  - o_grant still shows the owner.
  - Next state is always IDLE, where o_grant clears.
- Requester obligation:
  - Deassert i_req in the cycle after o_done.
  - A request still high in IDLE is treated as a new request, at lowest RR priority.
- Handshake timing:
  - Minimum request-to-first-pulse latency: req sampled in IDLE at edge T, RUN from T, o_pulse high from edge T+1.
  - Minimum gap between bursts: DONE cycle + IDLE cycle.
- Other requesters:
  - Requests raised or dropped during RUN/DONE are ignored until IDLE.
  - Config inputs of the owner are ignored after latching.
- Arithmetic:
  - Phase compares are unsigned CNT_W-bit; remaining is BURST_W-bit.
  - No counter ever exceeds its latched bound, so no overflow is possible.
- Reset mid-burst: next cycle IDLE, all outputs 0, RR pointer 0, no o_done issued.

Decomposition:
- Package pulse_sched_pkg:
  - State enum constants: ST_IDLE=0, ST_RUN=1, ST_DONE=2.
  - Default CNT_W/BURST_W localparams.
  - A function for the round-robin one-hot pick.
- Sub-module pulse_engine (natural split):
  - Inputs: i_clk, i_rst, i_start, i_abort, latched period/duration/count.
  - Outputs: o_pulse, o_last.
  - Contains the phase/remaining counters and the pulse register.
- Top level holds the arbiter, config latch, FSM and done/err logic.

Test Plan:
- Single burst: req0 with period=7, duration=3, count=2 -> o_grant=0001; o_pulse pattern 1110000 1110000 starting 1 cycle after RUN entry; o_done[0] after 14 RUN cycles; o_err=0.
- Round-robin: req0..req3 all held high, each with period=2, duration=1, count=1 -> grants in order 0,1,2,3, each granted once; after req0 re-asserts, it is served after req3.
- Bad config: req2 with period=5, duration=6, count=3 -> no o_pulse; DONE the cycle after grant; o_done[2]=1 with o_err=1.
- Abort: req1 with period=10, duration=4, count=5; drop i_req[1] at RUN cycle 13 -> DONE next cycle with o_err=1; o_pulse low within 2 cycles; IDLE after.
- Edge configs: duration=period=4, count=3 -> o_pulse high exactly 12 consecutive cycles. duration=0 -> o_pulse never high, o_done after count*period.
- Reset mid-RUN: assert i_rst at RUN cycle 5 -> next cycle o_grant=0, o_pulse=0, o_busy=0, no o_done; a fresh req3 is then served with correct timing.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : pulse_sched_pkg
// Shared state encoding, default widths and round-robin pick helper.
// Rev     : 1.0  initial release
// ============================================================================
package pulse_sched_pkg;

  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;
  localparam int DEF_CNT_W   = 7;
  localparam int DEF_BURST_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // One-hot of the first set bit of req searching upward from ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int                 ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [IDX_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = IDX_W'((ptr + k) % n);
      if (!found && (k < n) && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_engine.sv
`default_nettype none
// ============================================================================
// Module : pulse_engine
// Phase/remaining counters and registered pulse output for one burst.
// Rev    : 1.0  initial release
// ============================================================================
module pulse_engine
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [CNT_W-1:0]   i_duration,
  input  logic [BURST_W-1:0] i_count,
  output logic               o_pulse,
  output logic               o_last
);

  logic               r_active;
  logic [CNT_W-1:0]   r_phase;
  logic [BURST_W-1:0] r_remaining;
  logic               r_pulse;

  logic w_wrap;
  logic w_pulse_d;

  assign w_wrap    = (r_phase == (i_period - CNT_W'(1)));
  assign w_pulse_d = r_active && (r_phase < i_duration);
  assign o_last    = r_active && w_wrap && (r_remaining == BURST_W'(1));
  assign o_pulse   = r_pulse;

  // i_count is taken only on i_start; period/duration must stay stable while active.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active    <= 1'b0;
      r_phase     <= '0;
      r_remaining <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_pulse <= w_pulse_d;
      if (i_start) begin
        r_active    <= 1'b1;
        r_phase     <= '0;
        r_remaining <= i_count;
      end else if (r_active) begin
        if (i_abort || o_last) begin
          r_active    <= 1'b0;
          r_phase     <= '0;
          r_remaining <= '0;
        end else if (w_wrap) begin
          r_phase     <= '0;
          r_remaining <= r_remaining - BURST_W'(1);
        end else begin
          r_phase <= r_phase + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module : pulse_burst_scheduler
// Round-robin arbiter sharing one pulse engine between NUM_REQ requesters.
// Rev    : 1.0  initial release
// ============================================================================
module pulse_burst_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*CNT_W-1:0]   i_period,
  input  logic [NUM_REQ*CNT_W-1:0]   i_duration,
  input  logic [NUM_REQ*BURST_W-1:0] i_count,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_busy,
  output logic [NUM_REQ-1:0]         o_done,
  output logic                       o_err,
  output logic                       o_pulse
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_next;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_err;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_duration;

  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_win_idx;
  logic [CNT_W-1:0]   w_sel_period;
  logic [CNT_W-1:0]   w_sel_duration;
  logic [BURST_W-1:0] w_sel_count;
  logic               w_any_req;
  logic               w_bad_cfg;
  logic               w_start;
  logic               w_abort;
  logic               w_last;

  assign w_any_req = |i_req;
  assign w_pick    = NUM_REQ'(rr_pick(MAX_REQ'(i_req), int'(r_ptr), NUM_REQ));

  always_comb begin
    w_win_idx      = '0;
    w_sel_period   = '0;
    w_sel_duration = '0;
    w_sel_count    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_win_idx      = PTR_W'(i);
        w_sel_period   = i_period[i*CNT_W +: CNT_W];
        w_sel_duration = i_duration[i*CNT_W +: CNT_W];
        w_sel_count    = i_count[i*BURST_W +: BURST_W];
      end
    end
  end

  assign w_bad_cfg = (w_sel_period == '0) || (w_sel_count == '0) ||
                     (w_sel_duration > w_sel_period);
  assign w_start   = (r_state == ST_IDLE) && w_any_req && !w_bad_cfg;
  assign w_abort   = (r_state == ST_RUN) && ((i_req & r_grant) == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next = w_bad_cfg ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_abort || w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = '0;
    o_err  = 1'b0;
    if (r_state == ST_DONE) begin
      o_done = r_grant;
      o_err  = r_err;
    end
  end

  assign o_grant = r_grant;

  // Abort wins over a coincident final wrap: the owner withdrew, so report error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant    <= '0;
      r_ptr      <= '0;
      r_err      <= 1'b0;
      r_period   <= '0;
      r_duration <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant    <= w_pick;
            r_ptr      <= (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
            r_err      <= w_bad_cfg;
            r_period   <= w_sel_period;
            r_duration <= w_sel_duration;
          end
        end
        ST_RUN: begin
          r_err <= w_abort;
        end
        ST_DONE: begin
          r_grant <= '0;
          r_err   <= 1'b0;
        end
        default: begin
          r_grant <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  pulse_engine #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) u_engine (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .i_period   (r_period),
    .i_duration (r_duration),
    .i_count    (w_sel_count),
    .o_pulse    (o_pulse),
    .o_last     (w_last)
  );

endmodule
`default_nettype wire
